gobang_move_ctrl: RTL and testbench
===================================

GOBANG_MOVE_CTRL -- requirements
Module: gobang_move_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  new-game request; one-cycle pulse.
- move_valid  in  1  a candidate move is presented.
- move_x, move_y  in  4 each  candidate coordinates; 0..14 are legal.
- black_data, white_data  in  225 each  board occupancy; bit index = y*15 + x.
- black_x, black_y, black_xy, black_yx  in  9 each  black line windows centred on (get_x, get_y); bit 4 is the centre.
- white_x, white_y, white_xy, white_yx  in  9 each  white line windows, same layout.
- clr  out  1  board-clear pulse to the datapath.
- write  out  1  stone-write strobe.
- write_x, write_y  out  4 each  write coordinates.
- write_color  out  1  0 = black, 1 = white.
- get_x, get_y  out  4 each  probe coordinates for the line windows.
- move_ready  out  1  controller can accept a move.
- move_reject  out  1  one-cycle pulse when a move is refused.
- cur_color  out  1  side to move.
- game_over  out  1  game has ended.
- winner  out  2  00 none, 01 black, 10 white, 11 draw.
- move_count  out  8  number of stones placed, 0..225.

Function
REQ-002 SHALL implement the states IDLE, CHECK, WRITE, SETTLE, JUDGE and OVER.
REQ-003 In IDLE, move_ready SHALL be 1; in every other state it SHALL be 0.
REQ-004 In IDLE, when move_valid=1, the controller SHALL latch move_x and move_y into write_x/write_y and get_x/get_y, then go to CHECK.
REQ-005 In CHECK:
- If either coordinate is greater than 14, or (black_data|white_data) is set at index y*15+x, the controller SHALL pulse move_reject for 1 cycle and return to IDLE.
- Otherwise it SHALL go to WRITE.
- The index SHALL be evaluated only after the range check passes.
REQ-006 In WRITE:
- write SHALL be 1 for exactly 1 cycle, with write_color = cur_color.
- move_count SHALL increment by 1.
- The state SHALL then go to SETTLE.
REQ-007 SETTLE SHALL last 1 cycle with no outputs changing, so the datapath windows reflect the new stone.
REQ-008 In JUDGE, a win SHALL be declared if any of the four windows of cur_color contains 5 or more consecutive 1s.
REQ-009 On a win:
- winner SHALL be set to 01 when cur_color=0, or to 10 when cur_color=1.
- game_over SHALL be set to 1.
- The state SHALL go to OVER.
REQ-010 With no win and move_count=225, winner SHALL be set to 11, game_over to 1, and the state SHALL go to OVER.
REQ-011 Otherwise JUDGE SHALL toggle cur_color and return to IDLE.
REQ-012 In OVER, move_valid SHALL be ignored and outputs SHALL hold until start or rst.
REQ-013 start in any state, when rst=0, SHALL:
- pulse clr for 1 cycle;
- set cur_color=0, move_count=0, winner=00 and game_over=0;
- go to IDLE.
Any in-flight move SHALL be discarded.
REQ-014 If start and move_valid are both 1 in the same cycle, start SHALL win and the move SHALL be dropped.
REQ-015 write, clr and move_reject SHALL never be asserted in the same cycle.
REQ-016 A legal move SHALL take exactly 4 cycles from acceptance in IDLE to the return to IDLE: CHECK, WRITE, SETTLE, JUDGE.

Reset
REQ-017 While rst=1, the state SHALL be IDLE and every output SHALL be 0, including clr, write, move_reject, cur_color, game_over, winner, move_count, write_x/y and get_x/y.
REQ-018 rst SHALL take priority over start; a reset mid-move SHALL abort the move with no write issued.

Verification
REQ-019 Bench SHALL run: rst, then a move at (1,1) -> write=1 with (1,1) and color 0 three cycles after acceptance; move_count=1; cur_color=1.
REQ-020 Bench SHALL run: occupied (1,1) replayed -> move_reject pulse; no write; move_count unchanged.
REQ-021 Bench SHALL run: move_x=15 -> move_reject pulse; no write.
REQ-022 Bench SHALL run: black_x=9'b000111110 in JUDGE with cur_color=0 -> winner=01, game_over=1, and subsequent move_valid ignored.
REQ-023 Bench SHALL run: a 225th stone with no five-in-a-row -> winner=11 and game_over=1.
REQ-024 Bench SHALL run: start asserted in SETTLE -> clr pulse; no JUDGE; IDLE with move_count=0.

Source files
------------

// File: rtl/gobang_move_ctrl.sv
// Gobang move sequencer: validates a move, issues one stone write, then judges win/draw; registered strobes.
// A legal move spends CHECK/WRITE/SETTLE/JUDGE (4 cycles) before move_ready returns; moves are only taken in IDLE.
module gobang_move_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         move_valid,
  input  logic [3:0]   move_x,
  input  logic [3:0]   move_y,
  input  logic [224:0] black_data,
  input  logic [224:0] white_data,
  input  logic [8:0]   black_x,
  input  logic [8:0]   black_y,
  input  logic [8:0]   black_xy,
  input  logic [8:0]   black_yx,
  input  logic [8:0]   white_x,
  input  logic [8:0]   white_y,
  input  logic [8:0]   white_xy,
  input  logic [8:0]   white_yx,
  output logic         clr,
  output logic         write,
  output logic [3:0]   write_x,
  output logic [3:0]   write_y,
  output logic         write_color,
  output logic [3:0]   get_x,
  output logic [3:0]   get_y,
  output logic         move_ready,
  output logic         move_reject,
  output logic         cur_color,
  output logic         game_over,
  output logic [1:0]   winner,
  output logic [7:0]   move_count
);

  typedef enum logic [2:0] {IDLE, CHECK, WRITE, SETTLE, JUDGE, OVER} state_t;

  state_t       state, state_nxt;
  logic [224:0] occupied;
  logic         in_range;
  logic [7:0]   cell_idx;
  logic         cell_taken;
  logic         legal;
  logic         win;
  logic         board_full;

  function automatic logic has_five(input logic [8:0] w);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (w[i +: 5] == 5'b11111) hit = 1'b1;
    end
    return hit;
  endfunction

  // The board index is only formed once both coordinates are known to be on the board.
  always_comb begin
    occupied   = black_data | white_data;
    in_range   = (write_x <= 4'd14) && (write_y <= 4'd14);
    cell_idx   = in_range ? (8'(write_y) * 8'd15 + 8'(write_x)) : 8'd0;
    cell_taken = in_range ? occupied[cell_idx] : 1'b0;
    legal      = in_range && !cell_taken;
    win        = cur_color ? (has_five(white_x) || has_five(white_y) ||
                              has_five(white_xy) || has_five(white_yx))
                           : (has_five(black_x) || has_five(black_y) ||
                              has_five(black_xy) || has_five(black_yx));
    board_full = (move_count == 8'd225);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (move_valid) state_nxt = CHECK;
        CHECK:   state_nxt = legal ? WRITE : IDLE;
        WRITE:   state_nxt = SETTLE;
        SETTLE:  state_nxt = JUDGE;
        JUDGE:   state_nxt = (win || board_full) ? OVER : IDLE;
        OVER:    state_nxt = OVER;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign move_ready = (state == IDLE) && !rst;

  // Strobes default low each cycle; start overrides any in-flight action so clr never overlaps write/reject.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr         <= 1'b0;
      write       <= 1'b0;
      move_reject <= 1'b0;
      write_x     <= 4'd0;
      write_y     <= 4'd0;
      write_color <= 1'b0;
      get_x       <= 4'd0;
      get_y       <= 4'd0;
      cur_color   <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 2'b00;
      move_count  <= 8'd0;
    end else begin
      clr         <= 1'b0;
      write       <= 1'b0;
      move_reject <= 1'b0;
      if (start) begin
        clr        <= 1'b1;
        cur_color  <= 1'b0;
        move_count <= 8'd0;
        winner     <= 2'b00;
        game_over  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (move_valid) begin
              write_x <= move_x;
              write_y <= move_y;
              get_x   <= move_x;
              get_y   <= move_y;
            end
          end
          CHECK: begin
            if (!legal) move_reject <= 1'b1;
          end
          WRITE: begin
            write       <= 1'b1;
            write_color <= cur_color;
            move_count  <= move_count + 8'd1;
          end
          JUDGE: begin
            if (win) begin
              winner    <= cur_color ? 2'b10 : 2'b01;
              game_over <= 1'b1;
            end else if (board_full) begin
              winner    <= 2'b11;
              game_over <= 1'b1;
            end else begin
              cur_color <= ~cur_color;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gobang_move_ctrl.sv
// Directed bench for gobang_move_ctrl: legal/illegal moves, win, draw, start and reset priority.
module tb_gobang_move_ctrl;

  logic         clk = 1'b0;
  logic         rst, start, move_valid;
  logic [3:0]   move_x, move_y;
  logic [224:0] black_data, white_data;
  logic [8:0]   black_x, black_y, black_xy, black_yx;
  logic [8:0]   white_x, white_y, white_xy, white_yx;
  logic         clr, write, write_color, move_ready, move_reject, cur_color, game_over;
  logic [3:0]   write_x, write_y, get_x, get_y;
  logic [1:0]   winner;
  logic [7:0]   move_count;

  int n_cmp = 0;
  int n_err = 0;

  gobang_move_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .move_valid(move_valid),
    .move_x(move_x), .move_y(move_y),
    .black_data(black_data), .white_data(white_data),
    .black_x(black_x), .black_y(black_y), .black_xy(black_xy), .black_yx(black_yx),
    .white_x(white_x), .white_y(white_y), .white_xy(white_xy), .white_yx(white_yx),
    .clr(clr), .write(write), .write_x(write_x), .write_y(write_y),
    .write_color(write_color), .get_x(get_x), .get_y(get_y),
    .move_ready(move_ready), .move_reject(move_reject), .cur_color(cur_color),
    .game_over(game_over), .winner(winner), .move_count(move_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a move, run the full 5-edge sequence, then mark the cell occupied.
  task automatic do_move(input int x, input int y);
    move_x     = 4'(x);
    move_y     = 4'(y);
    move_valid = 1'b1;
    tick;
    move_valid = 1'b0;
    repeat (4) tick;
    if (x < 15 && y < 15) black_data[y*15 + x] = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; move_valid = 1'b0; move_x = 4'd0; move_y = 4'd0;
    black_data = '0; white_data = '0;
    black_x = '0; black_y = '0; black_xy = '0; black_yx = '0;
    white_x = '0; white_y = '0; white_xy = '0; white_yx = '0;

    // Reset state
    tick; tick;
    chk("rst_move_ready", move_ready, 0);
    chk("rst_write", write, 0);
    chk("rst_clr", clr, 0);
    chk("rst_move_count", move_count, 0);
    chk("rst_winner", winner, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_cur_color", cur_color, 0);
    chk("rst_get_x", get_x, 0);
    rst = 1'b0;
    tick;
    chk("idle_move_ready", move_ready, 1);

    // Legal move at (1,1)
    move_x = 4'd1; move_y = 4'd1; move_valid = 1'b1;
    tick;
    move_valid = 1'b0;
    chk("check_move_ready", move_ready, 0);
    chk("check_get_x", get_x, 1);
    chk("check_get_y", get_y, 1);
    tick;
    chk("wr_early_write", write, 0);
    tick;
    chk("wr_write", write, 1);
    chk("wr_write_x", write_x, 1);
    chk("wr_write_y", write_y, 1);
    chk("wr_write_color", write_color, 0);
    chk("wr_move_count", move_count, 1);
    black_data[16] = 1'b1;
    tick;
    chk("wr_one_cycle", write, 0);
    tick;
    chk("after_move_cur_color", cur_color, 1);
    chk("after_move_ready", move_ready, 1);
    chk("after_move_game_over", game_over, 0);

    // Occupied cell replayed
    move_x = 4'd1; move_y = 4'd1; move_valid = 1'b1;
    tick;
    move_valid = 1'b0;
    tick;
    chk("occ_reject", move_reject, 1);
    chk("occ_write", write, 0);
    chk("occ_move_count", move_count, 1);
    tick;
    chk("occ_reject_pulse", move_reject, 0);
    chk("occ_ready", move_ready, 1);

    // Off-board coordinate
    move_x = 4'd15; move_y = 4'd0; move_valid = 1'b1;
    tick;
    move_valid = 1'b0;
    tick;
    chk("range_reject", move_reject, 1);
    chk("range_write", write, 0);
    tick;
    chk("range_reject_pulse", move_reject, 0);
    chk("range_cur_color", cur_color, 1);
    chk("range_move_count", move_count, 1);

    // White plays, then black wins with five in the row window
    do_move(2, 2);
    chk("white_cur_color", cur_color, 0);
    chk("white_move_count", move_count, 2);
    black_x = 9'b000111110;
    do_move(3, 3);
    chk("win_winner", winner, 2'b01);
    chk("win_game_over", game_over, 1);
    chk("win_move_ready", move_ready, 0);
    chk("win_move_count", move_count, 3);
    black_x = '0;
    move_x = 4'd4; move_y = 4'd4; move_valid = 1'b1;
    repeat (3) tick;
    move_valid = 1'b0;
    chk("over_write", write, 0);
    chk("over_move_count", move_count, 3);
    chk("over_game_over", game_over, 1);
    chk("over_winner", winner, 2'b01);

    // New game, then fill the board without a five
    start = 1'b1;
    tick;
    start = 1'b0;
    black_data = '0; white_data = '0;
    chk("start_clr", clr, 1);
    chk("start_move_count", move_count, 0);
    chk("start_winner", winner, 0);
    chk("start_game_over", game_over, 0);
    chk("start_cur_color", cur_color, 0);
    chk("start_move_ready", move_ready, 1);
    tick;
    chk("start_clr_pulse", clr, 0);
    for (int i = 0; i < 224; i++) do_move(i % 15, i / 15);
    chk("fill_move_count", move_count, 224);
    chk("fill_game_over", game_over, 0);
    chk("fill_cur_color", cur_color, 0);
    do_move(14, 14);
    chk("draw_winner", winner, 2'b11);
    chk("draw_game_over", game_over, 1);
    chk("draw_move_count", move_count, 225);

    // start during SETTLE aborts the move before JUDGE
    start = 1'b1;
    tick;
    start = 1'b0;
    black_data = '0; white_data = '0;
    black_x = 9'b000111110;
    move_x = 4'd5; move_y = 4'd5; move_valid = 1'b1;
    tick;
    move_valid = 1'b0;
    tick; tick;
    chk("settle_write", write, 1);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("settle_clr", clr, 1);
    chk("settle_write_cleared", write, 0);
    chk("settle_move_count", move_count, 0);
    chk("settle_move_ready", move_ready, 1);
    tick; tick;
    chk("settle_no_judge_over", game_over, 0);
    chk("settle_no_judge_winner", winner, 0);
    chk("settle_clr_pulse", clr, 0);
    chk("settle_idle", move_ready, 1);
    black_x = '0;

    // start and move_valid together: the move is dropped
    start = 1'b1; move_valid = 1'b1; move_x = 4'd7; move_y = 4'd7;
    tick;
    start = 1'b0; move_valid = 1'b0;
    chk("both_clr", clr, 1);
    chk("both_move_ready", move_ready, 1);
    tick; tick;
    chk("both_no_write", write, 0);
    tick; tick;
    chk("both_move_count", move_count, 0);

    // Reset mid-move, asserted together with start
    move_x = 4'd8; move_y = 4'd8; move_valid = 1'b1;
    tick;
    move_valid = 1'b0;
    tick;
    rst = 1'b1; start = 1'b1;
    tick;
    chk("midrst_write", write, 0);
    chk("midrst_clr", clr, 0);
    chk("midrst_move_ready", move_ready, 0);
    chk("midrst_get_x", get_x, 0);
    chk("midrst_move_count", move_count, 0);
    rst = 1'b0; start = 1'b0;
    tick;
    chk("postrst_write", write, 0);
    chk("postrst_move_ready", move_ready, 1);
    chk("postrst_move_count", move_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
